// File: rtl/e32_pkg.sv
// Shared E32 definitions: default data width, flag bit indices and the
// common register-index / data-word types.
package e32_pkg;

  localparam int E32_XLEN = 32;
  localparam int E32_NREGS = 32;

  // Flag register bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef logic [$clog2(E32_NREGS)-1:0] reg_idx_t;
  typedef logic [E32_XLEN-1:0]          word_t;

endpackage

// File: rtl/e32_regfile_sb_if.sv
// Bus between decode/writeback (master) and the register file (slave).
//   enable              pipeline advance (read capture, flag update)
//   rd_sel/rd_data      read selects and registered read data, packed per port
//   rd_busy             per-port pending-write indication
//   wr_en/wr_sel/wr_data  writeback port
//   iss_en/iss_sel      long-latency destination issue
//   busy_vec            scoreboard state
//   flag_set/flag_mask/flag_in/flags  masked flag update and flag register
interface e32_regfile_sb_if
  import e32_pkg::*;
#(
  parameter int XLEN  = E32_XLEN,
  parameter int NREGS = E32_NREGS,
  parameter int NRD   = 2,
  parameter int FLAGW = 32
);
  localparam int AW = $clog2(NREGS);

  logic                enable;
  logic [NRD*AW-1:0]   rd_sel;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_sel;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_sel;
  logic [NREGS-1:0]    busy_vec;
  logic                flag_set;
  logic [FLAGW-1:0]    flag_mask;
  logic [FLAGW-1:0]    flag_in;
  logic [FLAGW-1:0]    flags;

  modport master (
    output enable, rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
           flag_set, flag_mask, flag_in,
    input  rd_data, rd_busy, busy_vec, flags
  );

  modport slave (
    input  enable, rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel,
           flag_set, flag_mask, flag_in,
    output rd_data, rd_busy, busy_vec, flags
  );

endinterface

// File: rtl/e32_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback (issue wins on collision), plus per-read-port lookup.
// Ports: clk, reset (sync, active-high), iss_en/iss_sel, wr_en/wr_sel,
//        rd_sel (packed per port), busy_vec, rd_busy.
module reg_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_sel,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_sel,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NREGS-1:0]  busy_vec,
  output logic [NRD-1:0]    rd_busy
);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (ZERO_REG && r == 0)
          busy_vec[r] <= 1'b0;
        else if (iss_en && iss_sel == AW'(r))
          busy_vec[r] <= 1'b1;
        else if (wr_en && wr_sel == AW'(r))
          busy_vec[r] <= 1'b0;
      end
    end
  end

  // A same-cycle writeback unblocks the reader: the bypass supplies the value.
  for (genvar p = 0; p < NRD; p++) begin : g_busy
    logic [AW-1:0] sel;
    assign sel        = rd_sel[p*AW +: AW];
    assign rd_busy[p] = busy_vec[sel] && !(wr_en && wr_sel == sel);
  end

endmodule

// File: rtl/e32_regfile_sb.sv
// E32 register file with registered read ports, write-to-read bypass,
// hardwired zero register, pending-write scoreboard and masked flag register.
// Ports: clk, reset (sync, active-high), bus (e32_regfile_sb_if.slave).
module e32_regfile_sb
  import e32_pkg::*;
#(
  parameter int XLEN     = E32_XLEN,
  parameter int NREGS    = E32_NREGS,
  parameter int NRD      = 2,
  parameter int FLAGW    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  e32_regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rd_data_w;
  logic [FLAGW-1:0]    flags_q;
  logic                wr_ok;

  // Writes to the zero register are dropped so it never holds a value.
  assign wr_ok = bus.wr_en && !(ZERO_REG && bus.wr_sel == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_sel] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] cap;
    logic [XLEN-1:0] q;

    assign sel = bus.rd_sel[p*AW +: AW];

    always_comb begin
      cap = regs[sel];
      if (ZERO_REG && sel == '0)
        cap = '0;
      else if (bus.wr_en && bus.wr_sel == sel)
        cap = bus.wr_data;
    end

    always_ff @(posedge clk) begin
      if (reset)           q <= '0;
      else if (bus.enable) q <= cap;
    end

    assign rd_data_w[p*XLEN +: XLEN] = q;
  end

  assign bus.rd_data = rd_data_w;

  always_ff @(posedge clk) begin
    if (reset)
      flags_q <= '0;
    else if (bus.enable && bus.flag_set)
      flags_q <= (flags_q & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask);
  end

  assign bus.flags = flags_q;

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_sel  (bus.iss_sel),
    .wr_en    (bus.wr_en),
    .wr_sel   (bus.wr_sel),
    .rd_sel   (bus.rd_sel),
    .busy_vec (bus.busy_vec),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_e32_regfile_sb.sv
module tb_e32_regfile_sb;
  import e32_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  e32_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .FLAGW(32)) ifc ();

  e32_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .FLAGW(32), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.wr_en = 1'b0; ifc.iss_en = 1'b0; ifc.flag_set = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifc.enable = 1'b1; ifc.rd_sel = '0;
    ifc.wr_en = 1'b0; ifc.wr_sel = '0; ifc.wr_data = '0;
    ifc.iss_en = 1'b0; ifc.iss_sel = '0;
    ifc.flag_set = 1'b0; ifc.flag_mask = '0; ifc.flag_in = '0;
    step(); step();
    reset = 1'b0;

    chk("rst_rd_data", 64'(ifc.rd_data), 64'h0);
    chk("rst_flags",   64'(ifc.flags),   64'h0);
    chk("rst_busy",    64'(ifc.busy_vec), 64'h0);
    chk("rst_rd_busy", 64'(ifc.rd_busy), 64'h0);
    for (int i = 0; i < 32; i++) begin
      ifc.rd_sel = {5'(i), 5'(i)};
      step();
      chk($sformatf("rst_read_r%0d", i), 64'(ifc.rd_data), 64'h0);
    end

    // Write with same-cycle read on port 0: bypass
    ifc.rd_sel = {5'd6, 5'd5};
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd5; ifc.wr_data = 32'hDEADBEEF;
    step();
    chk("bypass_p0", 64'(ifc.rd_data[31:0]),  64'hDEADBEEF);
    chk("bypass_p1", 64'(ifc.rd_data[63:32]), 64'h0);
    idle();
    ifc.rd_sel = {5'd5, 5'd5};
    step();
    chk("reread_both", 64'(ifc.rd_data), 64'hDEADBEEF_DEADBEEF);

    // Zero register ignores write and issue
    ifc.rd_sel = {5'd5, 5'd0};
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd0; ifc.wr_data = 32'h1234;
    ifc.iss_en = 1'b1; ifc.iss_sel = 5'd0;
    step();
    chk("zero_bypass", 64'(ifc.rd_data[31:0]), 64'h0);
    chk("zero_busy",   64'(ifc.busy_vec), 64'h0);
    idle();
    step();
    chk("zero_read", 64'(ifc.rd_data[31:0]), 64'h0);

    // Issue reg 7, then writeback clears it
    ifc.rd_sel = {5'd5, 5'd7};
    ifc.iss_en = 1'b1; ifc.iss_sel = 5'd7;
    step();
    idle();
    chk("iss7_busy_vec", 64'(ifc.busy_vec), 64'h80);
    chk("iss7_rd_busy",  64'(ifc.rd_busy),  64'h1);
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd7; ifc.wr_data = 32'h55;
    #1;
    chk("wb7_rd_busy_drop", 64'(ifc.rd_busy), 64'h0);
    step();
    idle();
    chk("wb7_rd_data",  64'(ifc.rd_data[31:0]), 64'h55);
    chk("wb7_busy_vec", 64'(ifc.busy_vec), 64'h0);

    // Issue and writeback to reg 9 together: issue wins, data written
    ifc.iss_en = 1'b1; ifc.iss_sel = 5'd9;
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd9; ifc.wr_data = 32'hA5A5A5A5;
    step();
    idle();
    chk("col9_busy_vec", 64'(ifc.busy_vec), 64'h200);
    ifc.rd_sel = {5'd9, 5'd9};
    #1;
    chk("col9_rd_busy", 64'(ifc.rd_busy), 64'h3);
    step();
    chk("col9_data", 64'(ifc.rd_data), 64'hA5A5A5A5_A5A5A5A5);

    // Flags
    ifc.flag_set = 1'b1; ifc.flag_mask = 32'hFFFFFFFF; ifc.flag_in = 32'hF;
    step();
    chk("flags_load", 64'(ifc.flags), 64'hF);
    ifc.flag_mask = (32'd1 << FLAG_Z) | (32'd1 << FLAG_C); ifc.flag_in = 32'h0;
    step();
    chk("flags_mask", 64'(ifc.flags), 64'hC);

    // Stall: flags and read data frozen, write still lands
    ifc.enable = 1'b0;
    ifc.flag_mask = 32'hC; ifc.flag_in = 32'h0;
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd9; ifc.wr_data = 32'h1111;
    step();
    idle();
    chk("stall_flags", 64'(ifc.flags), 64'hC);
    chk("stall_rd",    64'(ifc.rd_data), 64'hA5A5A5A5_A5A5A5A5);
    chk("stall_busy",  64'(ifc.busy_vec), 64'h0);
    ifc.enable = 1'b1;
    step();
    chk("reenable_rd", 64'(ifc.rd_data), 64'h1111_0000_1111);

    // Reset mid-stream overrides everything
    ifc.iss_en = 1'b1; ifc.iss_sel = 5'd3;
    step();
    chk("pre_rst_busy", 64'(ifc.busy_vec), 64'h8);
    reset = 1'b1;
    ifc.rd_sel = {5'd3, 5'd9};
    ifc.iss_sel = 5'd4;
    ifc.wr_en = 1'b1; ifc.wr_sel = 5'd9; ifc.wr_data = 32'h7777;
    ifc.flag_set = 1'b1; ifc.flag_mask = 32'hFF; ifc.flag_in = 32'hFF;
    step();
    idle();
    chk("mid_rst_rd",    64'(ifc.rd_data), 64'h0);
    chk("mid_rst_flags", 64'(ifc.flags), 64'h0);
    chk("mid_rst_busy",  64'(ifc.busy_vec), 64'h0);
    chk("mid_rst_rdbsy", 64'(ifc.rd_busy), 64'h0);
    reset = 1'b0;
    step();
    chk("post_rst_read", 64'(ifc.rd_data), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e32_regfile_sb.md
# e32_regfile_sb

Parametrised successor to the E32 core register file: an `NREGS` x `XLEN` register file with `NRD` registered read ports, same-cycle write-to-read bypass, and a hardwired zero register. It also holds a per-register pending-write scoreboard for long-latency producers and a masked flag register. It sits between decode (read selects, issue) and writeback (memory/bus/ALU results) in the E32 pipeline. It replaces the separate register file, read-data pipeline registers and flag register in the core top.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREGS`, 32, register count (power of two, ≥2); `AW = $clog2(NREGS)`
- `NRD`, 2, number of read ports
- `FLAGW`, 32, flag register width
- `ZERO_REG`, 1, register 0 reads 0 and ignores writes/issues

Ports:
- `clk` in 1 — single clock; all state on rising edge
- `reset` in 1 — synchronous, active-high
- `enable` in 1 — pipeline advance; gates read capture and flag update only
- `rd_sel` in NRD*AW — read selects, port p at [p*AW +: AW]
- `rd_data` out NRD*XLEN — registered read data
- `rd_busy` out NRD — selected register has a pending write (combinational)
- `wr_en` in 1, `wr_sel` in AW, `wr_data` in XLEN — writeback port
- `iss_en` in 1, `iss_sel` in AW — mark register pending (long-latency dest issued)
- `busy_vec` out NREGS — scoreboard state
- `flag_set` in 1, `flag_mask` in FLAGW, `flag_in` in FLAGW — masked flag update
- `flags` out FLAGW — flag register

## Operation
- Write: `wr_en` writes `wr_data` to `wr_sel` at the edge, independent of `enable`. It is ignored for reg 0 when `ZERO_REG`.
- Read: when `enable`, each port captures `regs[rd_sel]` into `rd_data`. When `!enable`, `rd_data` holds.
- Bypass: if `wr_en && wr_sel==rd_sel[p]` in the capturing cycle, `rd_data[p]` receives `wr_data` rather than the stale value. Reg 0 with `ZERO_REG` always captures 0.
- Scoreboard, per register r, next state:
  - set if `iss_en && iss_sel==r`;
  - else cleared if `wr_en && wr_sel==r`;
  - else hold.
  - Issue wins over a simultaneous writeback to the same register.
  - Issue to reg 0 is ignored when `ZERO_REG`.
  - Writeback to a non-busy register is a legal plain write.
- `rd_busy[p] = busy_vec[rd_sel[p]] && !(wr_en && wr_sel==rd_sel[p])`. A same-cycle writeback unblocks the reader because the bypass delivers the value.
- Flags: when `enable && flag_set`, `flags <= (flags & ~flag_mask) | (flag_in & flag_mask)`. Flag bits are defined in the package: Z=0, C=1, N=2, V=3.
- Reset: all registers, `rd_data`, `busy_vec` and `flags` are cleared to 0. Reset overrides any simultaneous write, issue or flag update.

## Timing
- Read latency: 1 cycle from `rd_sel` (with `enable`) to `rd_data`.
- Write → architectural state: 1 cycle. Write → read in the same cycle: 1 cycle via bypass.
- Issue → `busy_vec`/`rd_busy`: visible the cycle after `iss_en`.
- Writeback clear: `rd_busy` drops combinationally in the writeback cycle; `busy_vec` clears at the next edge.
- Multiple read ports selecting the same register: all return identical data.
- `enable` low for N cycles: `rd_data`/`flags` frozen; writes and scoreboard continue. On re-enable, the first capture reflects all writes made during the stall.
- Reset mid-operation: the cycle after `reset`, all outputs are 0 and `rd_busy` is 0, regardless of pending issues.

## Structure
- Shared package `e32_pkg`:
  - `XLEN` default;
  - flag index constants `FLAG_Z/C/N/V`;
  - typedefs `reg_idx_t` and `word_t`.
- Sub-module `reg_scoreboard`: the `NREGS`-bit busy vector with the issue/writeback priority and the `rd_busy` lookup, parametrised by `NREGS` and `NRD`.
- Top: register array, per-port read capture with bypass mux (generate loop over `NRD`), flag register.

## Test plan
- Reset, then read all regs on both ports → `rd_data`=0, `flags`=0, `busy_vec`=0.
- Write reg 5=`32'hDEADBEEF` while `rd_sel[0]`=5, `enable`=1 → next cycle `rd_data[0]`=`DEADBEEF` (bypass). Reading again later returns the same value.
- With `ZERO_REG`=1: write reg 0=`32'h1234` and issue reg 0 → reads return 0; `busy_vec[0]`=0.
- Issue reg 7 → `busy_vec[7]`=1 and `rd_busy`=1 for a reader of 7. Writeback 7=`32'h55` → `rd_busy` drops that cycle; `rd_data`=`55` next cycle; `busy_vec[7]`=0.
- Same-cycle issue and writeback to reg 9 → `busy_vec[9]` stays 1, reg 9 holds the written data.
- `flags`=`32'hF`, then `flag_set` with mask=`32'h3`, in=`32'h0` → `flags`=`32'hC`. The same update with `enable`=0 → `flags` unchanged. Assert `reset` mid-stream → all outputs 0 next cycle.
